booth_mult_ctrl: RTL and testbench

- Control FSM that sequences the Booth radix-2 multiplier datapath (accumulator A, multiplier register Q, extra bit Q[-1], multiplicand M).
- Accepts a start request and issues one-hot load/add/sub/shift strobes to the datapath for WIDTH iterations.
- Raises done and holds it until the consumer acknowledges.
- Sits between the multiplier's requester and the datapath registers; contains no arithmetic of its own.

---
 rtl/booth_ctrl_pkg.sv | 17 +
 rtl/booth_iter_counter.sv | 38 +++
 rtl/booth_mult_ctrl.sv | 87 ++++++++
 tb/tb_booth_mult_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/booth_ctrl_pkg.sv
// Shared state encoding and Booth op-decode constants for the radix-2
// multiplier controller.
package booth_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ARITH,
        SHIFT,
        DONE
    } booth_state_t;

    // Indexed by {q0, q_m1}; the other two pairs mean "shift only".
    localparam logic [1:0] BOOTH_OP_ADD = 2'b01;
    localparam logic [1:0] BOOTH_OP_SUB = 2'b10;

endpackage

// File: rtl/booth_iter_counter.sv
// Iteration counter for the Booth controller: counts completed shifts and
// flags the final one.
module booth_iter_counter #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             last
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign last  = (count_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/booth_mult_ctrl.sv
// Booth radix-2 multiplier control FSM: issues one-hot load/add/sub/shift
// strobes for WIDTH iterations, then holds done until acknowledged.
module booth_mult_ctrl
    import booth_ctrl_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             ready,
    input  logic             q0,
    input  logic             q_m1,
    output logic             load,
    output logic             add,
    output logic             sub,
    output logic             shift,
    output logic             done,
    input  logic             ack,
    output logic [CNT_W-1:0] iter
);

    booth_state_t     state_q;
    booth_state_t     state_d;
    logic             cnt_last;
    logic [1:0]       op_sel;

    assign op_sel = {q0, q_m1};

    booth_iter_counter #(
        .WIDTH (WIDTH)
    ) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (state_q == LOAD),
        .inc   (state_q == SHIFT),
        .count (iter),
        .last  (cnt_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ready   = 1'b0;
        load    = 1'b0;
        add     = 1'b0;
        sub     = 1'b0;
        shift   = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (start) state_d = LOAD;
            end
            LOAD: begin
                load    = 1'b1;
                state_d = ARITH;
            end
            ARITH: begin
                add     = (op_sel == BOOTH_OP_ADD);
                sub     = (op_sel == BOOTH_OP_SUB);
                state_d = SHIFT;
            end
            SHIFT: begin
                shift   = 1'b1;
                state_d = cnt_last ? DONE : ARITH;
            end
            DONE: begin
                // ack wins over a simultaneous start; start is simply dropped
                done = 1'b1;
                if (ack) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_booth_mult_ctrl.sv
// Directed bench for booth_mult_ctrl with a small Booth datapath model
// driving q0/q_m1 for the end-to-end product checks.
module tb_booth_mult_ctrl;

    localparam int WIDTH = 8;
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             clk = 1'b0;
    logic             rst, start, ack;
    logic             q0, q_m1;
    logic             ready, load, add, sub, shift, done;
    logic [CNT_W-1:0] iter;

    int tests = 0;
    int fails = 0;

    // forced operand bits or reference datapath
    logic use_model;
    logic fq0, fq1;

    logic signed [WIDTH-1:0] opM, opQ;
    logic [WIDTH-1:0]        mA, mQ;
    logic                    mQm1;
    logic [2*WIDTH:0]        sh;

    always #5 clk = ~clk;

    booth_mult_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .ready (ready),
        .q0    (q0),
        .q_m1  (q_m1),
        .load  (load),
        .add   (add),
        .sub   (sub),
        .shift (shift),
        .done  (done),
        .ack   (ack),
        .iter  (iter)
    );

    assign q0   = use_model ? mQ[0] : fq0;
    assign q_m1 = use_model ? mQm1  : fq1;
    assign sh   = {mA, mQ, mQm1};

    always @(posedge clk) begin
        if (load) begin
            mA   <= '0;
            mQ   <= opQ;
            mQm1 <= 1'b0;
        end else if (add) begin
            mA <= mA + opM;
        end else if (sub) begin
            mA <= mA - opM;
        end else if (shift) begin
            {mA, mQ, mQm1} <= {sh[2*WIDTH], sh[2*WIDTH:1]};
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // start is sampled at edge k; checks load, the ARITH/SHIFT cadence and done timing
    task automatic run_mult(input string tag, input int exp_add, input int exp_sub);
        int n_add = 0, n_sub = 0, n_pos = 0, n_multi = 0, n_done = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        check({tag, "_load"}, load, 1);
        check({tag, "_busy"}, ready, 0);
        for (int i = 1; i <= 2 * WIDTH; i++) begin
            step();
            n_add += int'(add);
            n_sub += int'(sub);
            if (shift != (i % 2 == 0)) n_pos++;
            if ((add || sub) && (i % 2 == 0)) n_pos++;
            if (int'(load) + int'(add) + int'(sub) + int'(shift) > 1) n_multi++;
            if (done || ready || load) n_done++;
        end
        check({tag, "_nadd"}, n_add, exp_add);
        check({tag, "_nsub"}, n_sub, exp_sub);
        check({tag, "_cadence"}, n_pos, 0);
        check({tag, "_onehot"}, n_multi, 0);
        check({tag, "_early_done"}, n_done, 0);
        step();
        check({tag, "_done"}, done, 1);
        check({tag, "_iter"}, iter, WIDTH);
        check({tag, "_done_busy"}, ready, 0);
    endtask

    task automatic ack_done(input string tag);
        ack = 1'b1;
        step();
        ack = 1'b0;
        check({tag, "_ack_ready"}, ready, 1);
        check({tag, "_ack_done"}, done, 0);
    endtask

    initial begin
        int bad;
        rst = 1'b1; start = 1'b1; ack = 1'b0;
        use_model = 1'b0; fq0 = 1'b0; fq1 = 1'b1;
        opM = '0; opQ = '0;

        // reset held two cycles with start asserted
        step(); step();
        check("rst_ready", ready, 1);
        check("rst_strobes", {load, add, sub, shift, done}, 0);
        check("rst_iter", iter, 0);
        rst = 1'b0; start = 1'b0;
        step(); step();
        check("idle_no_load", load, 0);
        ack = 1'b1;
        step();
        ack = 1'b0;
        check("idle_ack_ignored", {ready, load}, 2'b10);

        // {q0,q_m1}=01: add every ARITH
        fq0 = 1'b0; fq1 = 1'b1;
        run_mult("add01", WIDTH, 0);

        // done held without ack, start pulses ignored
        bad = 0;
        for (int j = 0; j < 6; j++) begin
            start = (j % 2 == 0);
            step();
            if (!done || ready || load) bad++;
        end
        start = 1'b0;
        check("hold_bad", bad, 0);
        check("hold_iter", iter, WIDTH);
        ack_done("add01");
        check("idle_iter_held", iter, WIDTH);

        fq0 = 1'b1; fq1 = 1'b0;
        run_mult("sub10", 0, WIDTH);
        ack_done("sub10");
        fq0 = 1'b0; fq1 = 1'b0;
        run_mult("nop00", 0, 0);
        ack_done("nop00");
        fq0 = 1'b1; fq1 = 1'b1;
        run_mult("nop11", 0, 0);
        ack_done("nop11");

        // reset sampled at edge k+7
        fq0 = 1'b0; fq1 = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (6) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_ready", ready, 1);
        check("midrst_strobes", {load, add, sub, shift, done}, 0);
        check("midrst_iter", iter, 0);
        bad = 0;
        for (int j = 0; j < 20; j++) begin
            step();
            if (done || load || shift) bad++;
        end
        check("midrst_quiet", bad, 0);
        run_mult("after_rst", WIDTH, 0);
        ack_done("after_rst");

        // reference datapath: (-3) x 7
        use_model = 1'b1;
        opM = -8'sd3; opQ = 8'sd7;
        run_mult("m3x7", 1, 1);
        check("m3x7_prod", {mA, mQ}, 16'hFFEB);

        // ack and start together: start dropped
        ack = 1'b1; start = 1'b1;
        step();
        ack = 1'b0; start = 1'b0;
        check("ackstart_ready", ready, 1);
        check("ackstart_no_load", load, 0);

        // start the following cycle: 127 x (-128)
        opM = 8'sd127; opQ = -8'sd128;
        run_mult("m127xm128", 0, 1);
        check("m127xm128_prod", {mA, mQ}, 16'hC080);
        ack_done("m127xm128");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
